// File: rtl/xt_keyboard_if_pkg.sv
// Shared types and constants for the XT keyboard receiver.
package xt_kbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FULL} kbd_state_e;

  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_TIMEOUT    = 16384;

  // I/O decode lives outside this block; these are the addresses it should use.
  localparam logic [7:0] KBD_PORT_DATA = 8'h60;
  localparam logic [7:0] KBD_PORT_CTRL = 8'h61;
endpackage

// File: rtl/xt_keyboard_if_if.sv
// CPU/PPI/PIC side of the keyboard block: port 60h strobes, PB7/PB6 control, irq.
interface xt_kbd_cpu_if;
  logic cs_n;
  logic rd_n;
  logic kbd_clr;
  logic kbd_clk_en;
  logic irq;

  modport slave  (input cs_n, rd_n, kbd_clr, kbd_clk_en, output irq);
  modport master (output cs_n, rd_n, kbd_clr, kbd_clk_en, input irq);
endinterface

// File: rtl/xt_keyboard_if_line_filter.sv
// Two-flop synchronizer plus run-length debounce; pulses fall for one cycle on a filtered 1->0.
module kbd_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic fall
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic          filt;
  logic [CW-1:0] cnt;
  logic          flip;

  // cnt counts consecutive samples disagreeing with filt; the last one flips it.
  assign flip = (sync[1] != filt) && (cnt == CW'(FILTER_LEN - 1));
  assign fall = flip && filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], line};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (flip) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/xt_keyboard_if.sv
// PC/XT keyboard receiver: assembles the serial scan code, latches it, raises irq and
// inhibits the keyboard until PB7 clears it; code readable on port 60h.
module xt_keyboard_if
  import xt_kbd_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kbd_clk,
  input  logic         kbd_data,
  output logic         kbd_clk_oe,
  inout  wire  [7:0]   d,
  xt_kbd_cpu_if.slave  cpu
);
  localparam int TW = $clog2(TIMEOUT + 1);

  kbd_state_e    state, state_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    scancode, scancode_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [1:0]    data_sync;
  logic          ev;
  logic          bit_in;

  kbd_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk  (clk),
    .rst  (rst),
    .line (kbd_clk),
    .fall (ev)
  );

  assign bit_in  = data_sync[1];
  assign cpu.irq = (state == ST_FULL);
  assign d       = (!cpu.cs_n && !cpu.rd_n) ? scancode : 8'bz;

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bitcnt_n   = bitcnt;
    scancode_n = scancode;
    tmo_n      = (tmo == TW'(TIMEOUT)) ? tmo : tmo + TW'(1);
    if (cpu.kbd_clr) begin
      // Clear dominates any event or frame completion in the same cycle.
      state_n    = ST_IDLE;
      shreg_n    = '0;
      bitcnt_n   = '0;
      scancode_n = '0;
      tmo_n      = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_n = '0;
          if (ev && bit_in) begin
            state_n  = ST_SHIFT;
            shreg_n  = '0;
            bitcnt_n = '0;
          end
        end
        ST_SHIFT: begin
          if (ev) begin
            shreg_n  = {bit_in, shreg[7:1]};
            bitcnt_n = bitcnt + 3'd1;
            tmo_n    = '0;
            if (bitcnt == 3'd7) begin
              scancode_n = {bit_in, shreg[7:1]};
              state_n    = ST_FULL;
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            // Keyboard stalled mid-frame: drop the partial byte.
            state_n = ST_IDLE;
            tmo_n   = '0;
          end
        end
        ST_FULL: tmo_n = '0;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      scancode   <= '0;
      tmo        <= '0;
      data_sync  <= 2'b11;
      kbd_clk_oe <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      scancode   <= scancode_n;
      tmo        <= tmo_n;
      data_sync  <= {data_sync[0], kbd_data};
      kbd_clk_oe <= (state_n == ST_FULL) || !cpu.kbd_clk_en;
    end
  end
endmodule
